// File: rtl/lsu_arbiter.sv
// lsu_arbiter: round-robin arbiter and fixed issue/capture/respond sequencer sharing the LSU between two requesters.
// Build macro LSU_ARB_FIXED_PRIO_EN: when defined, port 0 always wins a tie.
module lsu_arbiter #(
   parameter int unsigned       ADDR_W    = 32,
   parameter int unsigned       DATA_W    = 32,
   parameter logic [ADDR_W-1:0] PARK_ADDR = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req0_valid_i,
   output logic              req0_ready_o,
   input  logic [ADDR_W-1:0] req0_addr_i,
   input  logic [DATA_W-1:0] req0_wdata_i,
   input  logic              req0_we_i,
   output logic              rsp0_valid_o,
   output logic [DATA_W-1:0] rsp0_rdata_o,
   input  logic              req1_valid_i,
   output logic              req1_ready_o,
   input  logic [ADDR_W-1:0] req1_addr_i,
   input  logic [DATA_W-1:0] req1_wdata_i,
   input  logic              req1_we_i,
   output logic              rsp1_valid_o,
   output logic [DATA_W-1:0] rsp1_rdata_o,
   output logic [ADDR_W-1:0] lsu_addr_o,
   output logic [DATA_W-1:0] lsu_st_data_o,
   output logic              lsu_st_en_o,
   input  logic [DATA_W-1:0] lsu_ld_data_i
);

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_e;

   state_e            state_q, state_d;
   logic              gnt_valid, gnt_port, hs;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              we_q, port_q;
   logic [DATA_W-1:0] rdata0_q, rdata1_q;

`ifndef LSU_ARB_FIXED_PRIO_EN
   logic last_grant_q;
`endif

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      gnt_valid = req0_valid_i | req1_valid_i;
      gnt_port  = 1'b0;
      if (req0_valid_i && req1_valid_i) begin
`ifdef LSU_ARB_FIXED_PRIO_EN
         gnt_port = 1'b0;
`else
         gnt_port = ~last_grant_q;
`endif
      end else if (req1_valid_i) begin
         gnt_port = 1'b1;
      end
   end

   // Ready is held low in the reset cycle so no request is accepted and then discarded.
   assign req0_ready_o = (state_q == IDLE) && !rst_i && gnt_valid && !gnt_port;
   assign req1_ready_o = (state_q == IDLE) && !rst_i && gnt_valid &&  gnt_port;
   assign hs = (req0_valid_i && req0_ready_o) || (req1_valid_i && req1_ready_o);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (hs) state_d = ISSUE;
         ISSUE:   state_d = CAPTURE;
         CAPTURE: state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         addr_q   <= PARK_ADDR;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         port_q   <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q <= state_d;
         if (hs) begin
            addr_q  <= gnt_port ? req1_addr_i  : req0_addr_i;
            wdata_q <= gnt_port ? req1_wdata_i : req0_wdata_i;
            we_q    <= gnt_port ? req1_we_i    : req0_we_i;
            port_q  <= gnt_port;
         end
         // Stores echo the written word; peripherals may not read back what was stored.
         if (state_q == CAPTURE) begin
            if (port_q) rdata1_q <= we_q ? wdata_q : lsu_ld_data_i;
            else        rdata0_q <= we_q ? wdata_q : lsu_ld_data_i;
         end
      end
   end

`ifndef LSU_ARB_FIXED_PRIO_EN
   always_ff @(posedge clk_i) begin
      if (rst_i)   last_grant_q <= 1'b1;
      else if (hs) last_grant_q <= gnt_port;
   end
`endif

   // Address and store data stay put through CAPTURE: the LSU rewrites output registers on any addressed cycle.
   assign lsu_addr_o    = (state_q == ISSUE || state_q == CAPTURE) ? addr_q : PARK_ADDR;
   assign lsu_st_data_o = wdata_q;
   assign lsu_st_en_o   = (state_q == ISSUE) && we_q && !rst_i;

   assign rsp0_valid_o = (state_q == RESP) && !port_q && !rst_i;
   assign rsp1_valid_o = (state_q == RESP) &&  port_q && !rst_i;
   assign rsp0_rdata_o = rdata0_q;
   assign rsp1_rdata_o = rdata1_q;

endmodule

// File: tb/tb_lsu_arbiter.sv
// tb_lsu_arbiter: directed vector table plus hand-written reset and tie sequences, with a small LSU model.
module tb_lsu_arbiter;

   localparam logic [31:0] PARK = 32'h0000_0000;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        req0_valid_i = 1'b0, req0_ready_o, req0_we_i = 1'b0;
   logic [31:0] req0_addr_i = '0, req0_wdata_i = '0;
   logic        rsp0_valid_o;
   logic [31:0] rsp0_rdata_o;
   logic        req1_valid_i = 1'b0, req1_ready_o, req1_we_i = 1'b0;
   logic [31:0] req1_addr_i = '0, req1_wdata_i = '0;
   logic        rsp1_valid_o;
   logic [31:0] rsp1_rdata_o;
   logic [31:0] lsu_addr_o, lsu_st_data_o, lsu_ld_data_i;
   logic        lsu_st_en_o;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   lsu_arbiter dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .req0_valid_i  (req0_valid_i),
      .req0_ready_o  (req0_ready_o),
      .req0_addr_i   (req0_addr_i),
      .req0_wdata_i  (req0_wdata_i),
      .req0_we_i     (req0_we_i),
      .rsp0_valid_o  (rsp0_valid_o),
      .rsp0_rdata_o  (rsp0_rdata_o),
      .req1_valid_i  (req1_valid_i),
      .req1_ready_o  (req1_ready_o),
      .req1_addr_i   (req1_addr_i),
      .req1_wdata_i  (req1_wdata_i),
      .req1_we_i     (req1_we_i),
      .rsp1_valid_o  (rsp1_valid_o),
      .rsp1_rdata_o  (rsp1_rdata_o),
      .lsu_addr_o    (lsu_addr_o),
      .lsu_st_data_o (lsu_st_data_o),
      .lsu_st_en_o   (lsu_st_en_o),
      .lsu_ld_data_i (lsu_ld_data_i)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   // LSU model: data memory below 0x800, HEX0 output register at 0x800, switches at 0x9FF.
   logic [31:0] mem [0:511];
   logic [31:0] hex0 = '0;
   logic [7:0]  io_sw = 8'hA5;

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = '0;
      lsu_ld_data_i = '0;
   end

   always @(posedge clk_i) begin
      if (lsu_st_en_o && lsu_addr_o < 32'h800) mem[lsu_addr_o[10:2]] <= lsu_st_data_o;
      if (lsu_addr_o == 32'h800) hex0 <= lsu_st_data_o;
      if (lsu_addr_o == 32'h800)      lsu_ld_data_i <= hex0;
      else if (lsu_addr_o == 32'h9FF) lsu_ld_data_i <= {24'h0, io_sw};
      else                            lsu_ld_data_i <= mem[lsu_addr_o[10:2]];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive(input int p, input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
      if (p == 0) begin
         req0_valid_i = v; req0_we_i = we; req0_addr_i = a; req0_wdata_i = d;
      end else begin
         req1_valid_i = v; req1_we_i = we; req1_addr_i = a; req1_wdata_i = d;
      end
   endtask

   function automatic logic ready_of(input int p);
      return (p == 0) ? req0_ready_o : req1_ready_o;
   endfunction

   function automatic logic rsp_valid_of(input int p);
      return (p == 0) ? rsp0_valid_o : rsp1_valid_o;
   endfunction

   function automatic logic [31:0] rsp_rdata_of(input int p);
      return (p == 0) ? rsp0_rdata_o : rsp1_rdata_o;
   endfunction

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   typedef struct {
      int          port;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[6];

   // One isolated request: handshake in cycle 0, store strobe in cycle 1, response pulse in cycle 3.
   task automatic run_vec(input vec_t v);
      logic [31:0] other_rdata;
      other_rdata = rsp_rdata_of(1 - v.port);
      drive(v.port, 1'b1, v.we, v.addr, v.wdata);
      @(negedge clk_i);
      check("c0_ready", ready_of(v.port), 1'b1);
      check("c0_other_ready", ready_of(1 - v.port), 1'b0);
      check("c0_park_addr", lsu_addr_o, PARK);
      check("c0_st_en", lsu_st_en_o, 1'b0);
      next_cycle();
      drive(v.port, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk_i);
      check("c1_addr", lsu_addr_o, v.addr);
      check("c1_st_en", lsu_st_en_o, v.we);
      check("c1_st_data", lsu_st_data_o, v.wdata);
      next_cycle();
      @(negedge clk_i);
      check("c2_addr_hold", lsu_addr_o, v.addr);
      check("c2_st_en", lsu_st_en_o, 1'b0);
      check("c2_st_data_hold", lsu_st_data_o, v.wdata);
      check("c2_rsp_early", rsp_valid_of(v.port), 1'b0);
      next_cycle();
      @(negedge clk_i);
      check("c3_rsp_valid", rsp_valid_of(v.port), 1'b1);
      check("c3_rsp_rdata", rsp_rdata_of(v.port), v.exp_rdata);
      check("c3_other_valid", rsp_valid_of(1 - v.port), 1'b0);
      check("c3_other_rdata", rsp_rdata_of(1 - v.port), other_rdata);
      check("c3_park_addr", lsu_addr_o, PARK);
      next_cycle();
      @(negedge clk_i);
      check("c4_rsp_done", rsp_valid_of(v.port), 1'b0);
      check("c4_rdata_kept", rsp_rdata_of(v.port), v.exp_rdata);
   endtask

   int   exp_order[4];
   int   hs_cyc[4];
   int   gp;
   logic got;

   initial begin
      vecs[0] = '{0, 1'b1, 32'h0000_0010, 32'h1234_5678, 32'h1234_5678};
      vecs[1] = '{1, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'h1234_5678};
      vecs[2] = '{0, 1'b1, 32'h0000_0800, 32'h0000_00FF, 32'h0000_00FF};
      vecs[3] = '{1, 1'b0, 32'h0000_09FF, 32'h0000_0000, 32'h0000_00A5};
      vecs[4] = '{1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
      vecs[5] = '{0, 1'b0, 32'h0000_0020, 32'h0000_0000, 32'hDEAD_BEEF};
`ifdef LSU_ARB_FIXED_PRIO_EN
      exp_order = '{0, 0, 0, 0};
`else
      exp_order = '{0, 1, 0, 1};
`endif

      // Reset values
      next_cycle();
      @(negedge clk_i);
      check("rst_addr", lsu_addr_o, PARK);
      check("rst_st_en", lsu_st_en_o, 1'b0);
      check("rst_st_data", lsu_st_data_o, 32'h0);
      check("rst_rsp0_valid", rsp0_valid_o, 1'b0);
      check("rst_rsp1_valid", rsp1_valid_o, 1'b0);
      check("rst_rsp0_rdata", rsp0_rdata_o, 32'h0);
      check("rst_rsp1_rdata", rsp1_rdata_o, 32'h0);
      check("rst_ready0", req0_ready_o, 1'b0);
      next_cycle();
      rst_i = 1'b0;

      for (int i = 0; i < 6; i++) begin
         run_vec(vecs[i]);
         if (i == 2) check("hex0_value", hex0, 32'h0000_00FF);
         next_cycle();
      end

      // Reset during the ISSUE cycle of a store: strobe must drop in that same cycle.
      drive(1, 1'b1, 1'b1, 32'h0000_0030, 32'h0000_0055);
      @(negedge clk_i);
      check("rI_ready1", req1_ready_o, 1'b1);
      next_cycle();
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      rst_i = 1'b1;
      @(negedge clk_i);
      check("rI_st_en", lsu_st_en_o, 1'b0);
      next_cycle();
      rst_i = 1'b0;
      @(negedge clk_i);
      check("rI_park", lsu_addr_o, PARK);
      check("rI_mem_untouched", mem[12], 32'h0);
      next_cycle();

      // Reset during the CAPTURE cycle of a port 0 load: no response, back to IDLE.
      drive(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
      @(negedge clk_i);
      check("rC_ready0", req0_ready_o, 1'b1);
      next_cycle();
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      next_cycle();
      rst_i = 1'b1;
      @(negedge clk_i);
      check("rC_st_en", lsu_st_en_o, 1'b0);
      next_cycle();
      rst_i = 1'b0;
      @(negedge clk_i);
      check("rC_no_rsp", rsp0_valid_o, 1'b0);
      check("rC_park", lsu_addr_o, PARK);
      check("rC_rdata_cleared", rsp0_rdata_o, 32'h0);
      check("rC_st_en_after", lsu_st_en_o, 1'b0);
      next_cycle();
      @(negedge clk_i);
      check("rC_no_rsp_late", rsp0_valid_o, 1'b0);
      next_cycle();

      // Both ports valid continuously: grant order and one handshake per 4 cycles.
      drive(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
      drive(1, 1'b1, 1'b0, 32'h0000_0044, 32'h0);
      for (int k = 0; k < 4; k++) begin
         got = 1'b0;
         gp  = -1;
         for (int w = 0; w < 8; w++) begin
            @(negedge clk_i);
            if (req0_ready_o || req1_ready_o) begin
               got       = 1'b1;
               gp        = req0_ready_o ? 0 : 1;
               hs_cyc[k] = cyc;
               check("tie_single_ready", req0_ready_o & req1_ready_o, 1'b0);
               break;
            end
         end
         check("tie_hs_seen", got, 1'b1);
         check("tie_order", gp, exp_order[k]);
         if (k > 0 && got) check("tie_spacing", hs_cyc[k] - hs_cyc[k-1], 4);
      end
      next_cycle();
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (5) next_cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
